// File: rtl/fetch_pkg.sv
// Shared encodings and types for the RV32 instruction-fetch stage.
package fetch_pkg;

    localparam logic [1:0]  PCSRC_PLUS4 = 2'b00;
    localparam logic [1:0]  PCSRC_BR    = 2'b01;
    localparam logic [1:0]  PCSRC_JALR  = 2'b10;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    typedef enum logic [1:0] {
        RST_WAIT,
        RUN,
        DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order {pc, instr} queue between the memory response and decode.
// Head is read straight from registered storage; clear wins over push/pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int           DEPTH = 2,
    parameter fetch_entry_t INIT  = '0,
    localparam int          AW    = $clog2(DEPTH),
    localparam int          CW    = AW + 1
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          clear,
    input  logic          push,
    input  fetch_entry_t  push_dat,
    input  logic          pop,
    output fetch_entry_t  head_dat,
    output logic [CW-1:0] occupancy
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= INIT;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (push && !clear) mem_q[wr_ptr_q] <= push_dat;
        end
    end

    assign head_dat  = mem_q[rd_ptr_q];
    assign occupancy = cnt_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32 fetch: pipelined imem requests, in-order response buffer, redirect flush.
// First word reaches decode 3 cycles after reset release; requests stop when buffer+in-flight reach DEPTH.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] PCTargetE,
    input  logic [31:0] ALUResultE,
    input  logic        StallD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        ValidD,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PC_plus4D
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_state_t  state_q, state_d;
    logic [31:0]   pc_f_q, pc_f_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [31:0]   tag_mem_q [DEPTH];
    logic [AW-1:0] tag_wr_q, tag_wr_d;
    logic [AW-1:0] tag_rd_q, tag_rd_d;

    logic          redirect;
    logic [31:0]   target;
    logic          issue_ok, grant, pop, push, dropping;
    logic [CW-1:0] occ;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;

    always_comb begin
        redirect = 1'b0;
        target   = pc_f_q;
        case (PCSrc)
            PCSRC_BR: begin
                redirect = 1'b1;
                target   = word_align(PCTargetE);
            end
            PCSRC_JALR: begin
                redirect = 1'b1;
                target   = word_align(ALUResultE);
            end
            PCSRC_PLUS4: begin
            end
            default: begin
            end
        endcase
    end

    // Words already buffered plus words still in flight may never exceed DEPTH.
    assign issue_ok  = ({1'b0, occ} + {1'b0, outst_q}) < ((CW+1)'(DEPTH) + {{CW{1'b0}}, pop});
    assign imem_req  = (state_q != RST_WAIT) && !redirect && issue_ok;
    assign imem_addr = pc_f_q;
    assign grant     = imem_req && imem_gnt;

    assign ValidD    = (occ != '0) && !redirect;
    assign pop       = ValidD && !StallD;
    assign dropping  = imem_rvalid && (discard_q != '0);
    assign push      = imem_rvalid && (discard_q == '0) && !redirect;

    assign push_entry = '{pc: tag_mem_q[tag_rd_q], instr: imem_rdata};

    always_comb begin
        pc_f_d    = pc_f_q;
        discard_d = discard_q;
        tag_wr_d  = tag_wr_q;
        tag_rd_d  = tag_rd_q;
        outst_d   = outst_q + CW'(grant) - CW'(imem_rvalid);
        if (grant) begin
            pc_f_d   = pc_f_q + 32'd4;
            tag_wr_d = tag_wr_q + AW'(1);
        end
        if (dropping) discard_d = discard_q - CW'(1);
        if (push)     tag_rd_d  = tag_rd_q + AW'(1);
        // Everything still in flight after this edge belongs to the old path.
        if (redirect) begin
            pc_f_d    = target;
            discard_d = outst_d;
            tag_wr_d  = '0;
            tag_rd_d  = '0;
        end
        if (state_q == RST_WAIT) state_d = RUN;
        else                     state_d = (discard_d != '0) ? DRAIN : RUN;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= RST_WAIT;
            pc_f_q    <= RESET_PC;
            outst_q   <= '0;
            discard_q <= '0;
            tag_wr_q  <= '0;
            tag_rd_q  <= '0;
            for (int i = 0; i < DEPTH; i++) tag_mem_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            pc_f_q    <= pc_f_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
            tag_wr_q  <= tag_wr_d;
            tag_rd_q  <= tag_rd_d;
            if (grant) tag_mem_q[tag_wr_q] <= pc_f_q;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .INIT  (fetch_entry_t'{pc: RESET_PC, instr: NOP_INSTR})
    ) u_buf (
        .clk       (clk),
        .n_rst     (n_rst),
        .clear     (redirect),
        .push      (push),
        .push_dat  (push_entry),
        .pop       (pop),
        .head_dat  (head),
        .occupancy (occ)
    );

    assign InstrD    = ValidD ? head.instr : NOP_INSTR;
    assign PCD       = head.pc;
    assign PC_plus4D = head.pc + 32'd4;

endmodule
